// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART transmitter for the image pipeline.
//
// Bytes arrive as single-cycle pi_flag strobes and go into a 4-entry FIFO.
// They are sent as 8N1 frames, or as 8E1 frames when UART_TX_PARITY_EN is
// defined. Frames go out back-to-back while the FIFO holds data.
//
// Compile-time option:
//   UART_TX_PARITY_EN  adds the even-parity bit (PARITY state), 11-bit frames.
//
// Parameters:
//   CNT_BAUD_MAX  baud counter terminal value; one bit = CNT_BAUD_MAX+1 clocks.
//
// Ports:
//   sclk      system clock, rising edge
//   rst       asynchronous active-high reset
//   pi_data   byte to send, sampled when pi_flag=1
//   pi_flag   single-cycle write strobe
//   full      FIFO holds 4 bytes
//   ovf_flag  one-cycle pulse after a strobe is dropped because FIFO was full
//   busy      a frame is on the line
//   tx        serial line, registered, idle high
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned CNT_BAUD_MAX = 5207
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       full,
  output logic       ovf_flag,
  output logic       busy,
  output logic       tx
);

  localparam logic [12:0] BAUD_MAX = 13'(CNT_BAUD_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic       fifo_rdy;
  logic [7:0] fifo_head;

  assign full      = (count == 3'd4);
  // A strobe is dropped whenever the FIFO is full before the edge, even if
  // the FSM pops in the same cycle.
  assign push      = pi_flag & ~full;
  assign fifo_head = fifo_mem[rd_ptr];

  always_ff @(posedge sclk) begin
    if (push) fifo_mem[wr_ptr] <= pi_data;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      ovf_flag <= 1'b0;
      fifo_rdy <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      ovf_flag <= pi_flag & full;
      // Registered non-empty view used only for the start out of IDLE; this
      // gives the two-edge strobe-to-start-bit latency and keeps the FIFO
      // count off the IDLE decision path.
      fifo_rdy <= (count != 3'd0);
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [12:0] cnt_baud;
  logic [12:0] cnt_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_nxt;
  logic [7:0]  shift;
  logic [7:0]  shift_nxt;
  logic        tx_nxt;
  logic        bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Even parity of the byte is latched as it leaves the FIFO.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst)      par_q <= 1'b0;
    else if (pop) par_q <= ^fifo_head;
  end
`endif

  assign bit_end = (cnt_baud == BAUD_MAX);

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    // Counter runs in every non-IDLE state and wraps at each bit end; it is
    // held at 0 in IDLE so the first bit of a frame starts from 0.
    cnt_nxt     = (state == IDLE || bit_end) ? 13'd0 : cnt_baud + 13'd1;

    case (state)
      IDLE: begin
        if (fifo_rdy && count != 3'd0) begin
          pop         = 1'b1;
          shift_nxt   = fifo_head;
          bit_cnt_nxt = 3'd0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = {1'b0, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          // Back-to-back: next start bit directly follows the stop bit.
          if (count != 3'd0) begin
            pop         = 1'b1;
            shift_nxt   = fifo_head;
            bit_cnt_nxt = 3'd0;
            state_nxt   = START;
          end else begin
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level for the bit being entered, so tx changes with the state.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_q;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt_baud <= 13'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_baud <= cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx with CNT_BAUD_MAX=7.
// A window of cycles is driven from a strobe table; outputs are logged each
// cycle and compared with a frame-level reference model. Cycle index i in a
// window is the state just after the i-th clock edge of that window; a strobe
// placed at index i is sampled by that edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CBM  = 7;
  localparam int BITC = CBM + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * BITC;
  localparam int MAXL  = 4000;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic       full, ovf_flag, busy, tx;

  uart_tx #(.CNT_BAUD_MAX(CBM)) dut (
    .sclk(sclk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .full(full), .ovf_flag(ovf_flag), .busy(busy), .tx(tx)
  );

  always #5 sclk = ~sclk;

  int tests = 0;
  int fails = 0;

  logic       stb_v [MAXL];
  logic [7:0] stb_d [MAXL];
  logic l_tx [MAXL], l_busy [MAXL], l_full [MAXL], l_ovf [MAXL];
  logic e_tx [MAXL], e_busy [MAXL], e_full [MAXL], e_ovf [MAXL];
  logic [7:0] exp_bytes [$];
  logic [7:0] dec_bytes [$];

  task automatic clear_stim();
    for (int i = 0; i < MAXL; i++) begin
      stb_v[i] = 1'b0;
      stb_d[i] = 8'h00;
    end
  endtask

  // Drive the strobe table for L cycles and log the outputs.
  task automatic run(input int L);
    @(posedge sclk); #1;
    for (int i = 0; i < L; i++) begin
      if (i + 1 < L) begin
        pi_flag = stb_v[i+1];
        pi_data = stb_d[i+1];
      end else begin
        pi_flag = 1'b0;
      end
      @(negedge sclk);
      l_tx[i] = tx; l_busy[i] = busy; l_full[i] = full; l_ovf[i] = ovf_flag;
      @(posedge sclk); #1;
    end
    pi_flag = 1'b0;
  endtask

  // Line level of bit b of the frame carrying d.
  function automatic logic bitval(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (FB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Reference: bytes queue up to 4 deep; a frame starts two edges after its
  // byte was accepted when the line is free, or straight after a stop bit if
  // data is waiting. Strobes seen while 4 bytes are held are dropped.
  task automatic model(input int L);
    logic [7:0] qd [$];
    int         qa [$];
    bit         inf;
    bit         fb;
    int         fs, fe;
    logic [7:0] fd;
    exp_bytes.delete();
    inf = 0; fs = 0; fe = 0; fd = 8'h00;
    e_tx[0] = 1'b1; e_busy[0] = 1'b0; e_full[0] = 1'b0; e_ovf[0] = 1'b0;
    for (int i = 1; i < L; i++) begin
      fb = (qd.size() == 4);
      if (inf && i == fe) inf = 0;
      if (!inf && qd.size() > 0 && (i == fe || qa[0] <= i - 2)) begin
        fd = qd.pop_front();
        void'(qa.pop_front());
        inf = 1; fs = i; fe = i + FRAME;
        exp_bytes.push_back(fd);
      end
      if (stb_v[i] && !fb) begin
        qd.push_back(stb_d[i]);
        qa.push_back(i);
      end
      e_ovf[i]  = stb_v[i] && fb;
      e_full[i] = (qd.size() == 4);
      e_busy[i] = inf;
      e_tx[i]   = inf ? bitval(fd, (i - fs) / BITC) : 1'b1;
    end
  endtask

  // Recover bytes from the logged line by sampling mid-bit.
  task automatic decode(input int L);
    int i;
    logic [7:0] d;
    dec_bytes.delete();
    i = 1;
    while (i < L) begin
      if (l_tx[i-1] == 1'b1 && l_tx[i] == 1'b0 && i + FRAME <= L) begin
        for (int b = 0; b < 8; b++) d[b] = l_tx[i + BITC*(b+1) + BITC/2];
        dec_bytes.push_back(d);
        i = i + FRAME - BITC/2;
      end else begin
        i++;
      end
    end
  endtask

  function automatic logic sig_got(input int s, input int k);
    case (s)
      0: return l_tx[k];
      1: return l_busy[k];
      2: return l_full[k];
      default: return l_ovf[k];
    endcase
  endfunction

  function automatic logic sig_exp(input int s, input int k);
    case (s)
      0: return e_tx[k];
      1: return e_busy[k];
      2: return e_full[k];
      default: return e_ovf[k];
    endcase
  endfunction

  function automatic string sname(input int s);
    case (s)
      0: return "tx";
      1: return "busy";
      2: return "full";
      default: return "ovf_flag";
    endcase
  endfunction

  function automatic int first_diff(input int s, input int L);
    for (int k = 0; k < L; k++)
      if (sig_got(s, k) !== sig_exp(s, k)) return k;
    return -1;
  endfunction

  function automatic int qdiff(input logic [7:0] a [$], input logic [7:0] b [$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int k = 0; k < n; k++) if (a[k] !== b[k]) return k;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic int count_ones_busy(input int L);
    int c = 0;
    for (int k = 0; k < L; k++) if (l_busy[k] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_ones_ovf(input int L);
    int c = 0;
    for (int k = 0; k < L; k++) if (l_ovf[k] === 1'b1) c++;
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1;
    tests++; if (tx !== 1'b1)       begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (full !== 1'b0)     begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (ovf_flag !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf_flag); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int k;
    clear_stim();
    run(1000);
    model(1000);
    for (int s = 0; s < 2; s++) begin
      k = first_diff(s, 1000); tests++;
      if (k != -1) begin fails++; $display("FAIL idle/%s cycle %0d: got %b want %b", sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
  endtask

  task automatic test_single();
    int k, bad, L;
    int lv [11];
`ifdef UART_TX_PARITY_EN
    lv = '{0,1,0,1,0,0,1,0,1,0,1};
`else
    lv = '{0,1,0,1,0,0,1,0,1,1,1};
`endif
    L = 100;
    clear_stim();
    stb_v[1] = 1'b1; stb_d[1] = 8'hA5;
    run(L);
    model(L);
    for (int s = 0; s < 4; s++) begin
      k = first_diff(s, L); tests++;
      if (k != -1) begin fails++; $display("FAIL single/%s cycle %0d: got %b want %b", sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
    tests++;
    if ({l_tx[2], l_tx[3]} !== 2'b10) begin fails++; $display("FAIL single_start_edge: got %b%b want 10", l_tx[2], l_tx[3]); end
    bad = 0;
    for (int b = 0; b < FB; b++)
      for (int j = 0; j < BITC; j++)
        if (l_tx[3 + BITC*b + j] !== lv[b][0]) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL single_levels: got %0d wrong cycles want 0", bad); end
    tests++;
    if (count_ones_busy(L) !== FRAME) begin fails++; $display("FAIL single_busy_len: got %0d want %0d", count_ones_busy(L), FRAME); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity_01();
    int L;
    L = 110;
    clear_stim();
    stb_v[1] = 1'b1; stb_d[1] = 8'h01;
    run(L);
    tests++;
    if (l_tx[3 + BITC*9 + BITC/2] !== 1'b1) begin fails++; $display("FAIL parity_bit: got %b want 1", l_tx[3 + BITC*9 + BITC/2]); end
    tests++;
    if (count_ones_busy(L) !== 88) begin fails++; $display("FAIL parity_frame_len: got %0d want 88", count_ones_busy(L)); end
  endtask
`endif

  task automatic test_back_to_back();
    int k, L;
    logic [7:0] want [$];
    L = 3 + 5*FRAME + 20;
    clear_stim();
    want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin stb_v[1+i] = 1'b1; stb_d[1+i] = want[i]; end
    run(L);
    model(L);
    decode(L);
    for (int s = 0; s < 4; s++) begin
      k = first_diff(s, L); tests++;
      if (k != -1) begin fails++; $display("FAIL b2b/%s cycle %0d: got %b want %b", sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
    k = qdiff(dec_bytes, want); tests++;
    if (k != -1) begin fails++; $display("FAIL b2b_bytes: got %0d bytes want 5 (first diff at %0d)", dec_bytes.size(), k); end
    tests++;
    if (count_ones_busy(L) !== 5*FRAME) begin fails++; $display("FAIL b2b_busy_len: got %0d want %0d", count_ones_busy(L), 5*FRAME); end
    tests++;
    if (count_ones_ovf(L) !== 0) begin fails++; $display("FAIL b2b_ovf: got %0d pulses want 0", count_ones_ovf(L)); end
  endtask

  task automatic test_overflow();
    int k, L;
    logic [7:0] want [$];
    L = 3 + 5*FRAME + 20;
    clear_stim();
    for (int i = 0; i < 6; i++) begin
      stb_v[1+i] = 1'b1;
      stb_d[1+i] = 8'($urandom_range(0, 255));
      if (i < 5) want.push_back(stb_d[1+i]);
    end
    run(L);
    model(L);
    decode(L);
    for (int s = 0; s < 4; s++) begin
      k = first_diff(s, L); tests++;
      if (k != -1) begin fails++; $display("FAIL ovf/%s cycle %0d: got %b want %b", sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
    tests++;
    if ({l_full[4], l_full[5], l_full[6]} !== 3'b011) begin fails++; $display("FAIL ovf_full_window: got %b%b%b want 011", l_full[4], l_full[5], l_full[6]); end
    tests++;
    if (l_ovf[6] !== 1'b1 || count_ones_ovf(L) !== 1) begin fails++; $display("FAIL ovf_pulse: got %0d pulses (at N+5: %b) want 1", count_ones_ovf(L), l_ovf[6]); end
    k = qdiff(dec_bytes, want); tests++;
    if (k != -1) begin fails++; $display("FAIL ovf_bytes: got %0d frames want 5 (first diff at %0d)", dec_bytes.size(), k); end
  endtask

  task automatic test_random(input int round);
    int k, idx, L;
    clear_stim();
    idx = 0;
    for (int n = 0; n < 12; n++) begin
      idx += 1 + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 100));
      stb_v[idx] = 1'b1;
      stb_d[idx] = 8'($urandom_range(0, 255));
    end
    L = idx + 12*FRAME + 20;
    run(L);
    model(L);
    decode(L);
    for (int s = 0; s < 4; s++) begin
      k = first_diff(s, L); tests++;
      if (k != -1) begin fails++; $display("FAIL random%0d/%s cycle %0d: got %b want %b", round, sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
    k = qdiff(dec_bytes, exp_bytes); tests++;
    if (k != -1) begin fails++; $display("FAIL random%0d_bytes: got %0d frames want %0d (first diff at %0d)", round, dec_bytes.size(), exp_bytes.size(), k); end
  endtask

  task automatic test_reset_mid();
    int bad, k;
    @(posedge sclk); #1;
    for (int i = 0; i < 5; i++) begin
      pi_flag = 1'b1; pi_data = 8'hFF;
      @(posedge sclk); #1;
    end
    pi_flag = 1'b0;
    repeat (20) @(posedge sclk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL rstmid_pre_full: got %b want 1", full); end
    rst = 1'b1;
    #1;
    tests++; if (tx !== 1'b1)   begin fails++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL rstmid_full: got %b want 0", full); end
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sclk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
    clear_stim();
    stb_v[1] = 1'b1; stb_d[1] = 8'h3C;
    run(100);
    model(100);
    for (int s = 0; s < 2; s++) begin
      k = first_diff(s, 100); tests++;
      if (k != -1) begin fails++; $display("FAIL rstmid_restart/%s cycle %0d: got %b want %b", sname(s), k, sig_got(s, k), sig_exp(s, k)); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
`ifdef UART_TX_PARITY_EN
    test_parity_01();
`endif
    test_back_to_back();
    test_overflow();
    test_random(0);
    test_random(1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
